// File: rtl/muxn_pkg.sv
// Shared encodings and width helpers for the muxn_scan block.
package muxn_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_e;

  // Index width that never collapses to zero bits (values 1 and 2 both need one bit).
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 32'd2) ? 32'd1 : 32'($clog2(v));
  endfunction

endpackage

// File: rtl/muxn_comb.sv
// Combinational N:1 selector of W-bit channels; out-of-range s yields zero.
module muxn_comb
  import muxn_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 8,
  parameter int unsigned SW = clog2_min1(N)
) (
  input  logic [N*W-1:0] x,
  input  logic [SW-1:0]  s,
  output logic [W-1:0]   y
);

  // Pick channel s from the flattened input vector.
  always_comb begin
    y = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (s == SW'(i)) y = x[i*W +: W];
    end
  end

endmodule

// File: rtl/muxn_scan.sv
// Registered N-channel mux with manual select and auto-scan, plus channel index and change strobe.
module muxn_scan
  import muxn_pkg::*;
#(
  parameter  int unsigned N     = 4,
  parameter  int unsigned W     = 8,
  parameter  int unsigned DWELL = 4,
  localparam int unsigned SW    = clog2_min1(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] x,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  input  logic           hold,
  output logic [W-1:0]   f,
  output logic [SW-1:0]  ch,
  output logic           valid
);

  localparam int unsigned   CW       = clog2_min1(DWELL);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [SW-1:0] CH_LAST  = SW'(N - 1);
  localparam logic [SW:0]   N_EXT    = (SW + 1)'(N);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [SW-1:0] r_ch;
  logic [SW-1:0] w_ch_nxt;
  logic [W-1:0]  r_f;
  logic [W-1:0]  w_f_nxt;
  logic          r_valid;
  logic          w_sel_ok;

  // Compare one bit wider so a power-of-two N does not wrap to zero.
  assign w_sel_ok = ({1'b0, sel} < N_EXT);

  // State register; frozen while hold is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_state <= ST_MANUAL;
    else if (!hold) r_state <= w_state_nxt;
  end

  // Next state simply tracks the mode input.
  always_comb begin
    w_state_nxt = ST_MANUAL;
    if (mode == MODE_SCAN) w_state_nxt = ST_SCAN;
  end

  // Next channel and dwell count; the MANUAL->SCAN switch edge only arms the scan.
  always_comb begin
    w_ch_nxt  = r_ch;
    w_cnt_nxt = '0;
    if (mode == MODE_MANUAL) begin
      if (w_sel_ok) w_ch_nxt = sel;
    end else if (r_state == ST_SCAN) begin
      if (r_cnt == CNT_LAST) begin
        w_cnt_nxt = '0;
        w_ch_nxt  = (r_ch == CH_LAST) ? '0 : r_ch + SW'(1);
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
  end

  muxn_comb #(
    .N  (N),
    .W  (W),
    .SW (SW)
  ) u_sel (
    .x (x),
    .s (w_ch_nxt),
    .y (w_f_nxt)
  );

  // Datapath registers: data, channel, strobe and dwell counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch    <= '0;
      r_f     <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (hold) begin
      r_valid <= 1'b0;
    end else begin
      r_ch    <= w_ch_nxt;
      r_f     <= w_f_nxt;
      r_valid <= (w_ch_nxt != r_ch);
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign f     = r_f;
  assign ch    = r_ch;
  assign valid = r_valid;

endmodule

// File: tb/tb_muxn_scan.sv
// Directed scoreboard bench for muxn_scan across three parameter sets.
module tb_muxn_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // dut 0: N=4 W=8 DWELL=4
  logic [31:0] xa;
  logic [1:0]  sela;
  logic        modea, holda;
  logic [7:0]  fa;
  logic [1:0]  cha;
  logic        va;

  // dut 1: N=3 W=8 DWELL=2
  logic [23:0] xb;
  logic [1:0]  selb;
  logic        modeb, holdb;
  logic [7:0]  fb;
  logic [1:0]  chb;
  logic        vb;

  // dut 2: N=4 W=8 DWELL=1
  logic [31:0] xc;
  logic [1:0]  selc;
  logic        modec, holdc;
  logic [7:0]  fc;
  logic [1:0]  chc;
  logic        vc;

  muxn_scan #(.N(4), .W(8), .DWELL(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .x(xa), .sel(sela), .mode(modea), .hold(holda),
    .f(fa), .ch(cha), .valid(va)
  );

  muxn_scan #(.N(3), .W(8), .DWELL(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .x(xb), .sel(selb), .mode(modeb), .hold(holdb),
    .f(fb), .ch(chb), .valid(vb)
  );

  muxn_scan #(.N(4), .W(8), .DWELL(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .x(xc), .sel(selc), .mode(modec), .hold(holdc),
    .f(fc), .ch(chc), .valid(vc)
  );

  typedef struct {
    int         d;
    logic [7:0] f;
    logic [7:0] ch;
    logic       v;
    int         tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  // Expected tables for the scan sequences.
  int         bch [8]  = '{0, 0, 1, 1, 2, 2, 0, 0};
  logic       bv  [8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] bval[3]  = '{8'hAA, 8'h22, 8'h33};
  logic [7:0] cval[4]  = '{8'h11, 8'h22, 8'h33, 8'h44};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input int d, input logic [7:0] f, input logic [7:0] ch, input logic v);
    exp_t e;
    step++;
    e.d   = d;
    e.f   = f;
    e.ch  = ch;
    e.v   = v;
    e.tag = step;
    sb.push_back(e);
  endtask

  task automatic observe(input int d, output logic [7:0] of, output logic [7:0] och,
                         output logic ov);
    case (d)
      0:       begin of = fa; och = {6'b0, cha}; ov = va; end
      1:       begin of = fb; och = {6'b0, chb}; ov = vb; end
      default: begin of = fc; och = {6'b0, chc}; ov = vc; end
    endcase
  endtask

  // Advance one edge, then drain and compare all pending expectations.
  task automatic tick();
    exp_t       e;
    logic [7:0] of, och;
    logic       ov;
    @(posedge clk);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      observe(e.d, of, och, ov);
      chk($sformatf("d%0d_s%0d_f", e.d, e.tag), of, e.f);
      chk($sformatf("d%0d_s%0d_ch", e.d, e.tag), och, e.ch);
      chk($sformatf("d%0d_s%0d_valid", e.d, e.tag), {7'b0, ov}, {7'b0, e.v});
    end
  endtask

  task automatic chk_reset(input int d, input string tag);
    logic [7:0] of, och;
    logic       ov;
    observe(d, of, och, ov);
    chk($sformatf("%s_d%0d_f", tag, d), of, 8'h00);
    chk($sformatf("%s_d%0d_ch", tag, d), och, 8'h00);
    chk($sformatf("%s_d%0d_valid", tag, d), {7'b0, ov}, 8'h00);
  endtask

  initial begin
    rst_n = 1'b1;
    xa = 32'h44332211; sela = 2'd2; modea = 1'b0; holda = 1'b0;
    xb = 24'h332211;   selb = 2'd0; modeb = 1'b0; holdb = 1'b0;
    xc = 32'h44332211; selc = 2'd0; modec = 1'b0; holdc = 1'b0;
    repeat (2) @(posedge clk);

    // Async reset between edges: outputs clear with no clock.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) chk_reset(d, "async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Manual select after release.
    push(0, 8'h33, 8'd2, 1'b1); tick();
    push(0, 8'h33, 8'd2, 1'b0); tick();

    // Manual out-of-range on N=3, with live refresh of the held channel.
    selb = 2'd2;
    push(1, 8'h33, 8'd2, 1'b1); tick();
    selb = 2'd3;
    xb   = 24'h3322AA;
    push(1, 8'h33, 8'd2, 1'b0); tick();
    push(1, 8'h33, 8'd2, 1'b0); tick();
    selb = 2'd0;
    push(1, 8'hAA, 8'd0, 1'b1); tick();
    push(1, 8'hAA, 8'd0, 1'b0); tick();

    // Scan wrap N=3 DWELL=2; channel 1 data changes mid-dwell.
    modeb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        xb      = 24'h3355AA;
        bval[1] = 8'h55;
      end
      push(1, bval[bch[i]], 8'(bch[i]), bv[i]);
      tick();
    end
    modeb = 1'b0;

    // DWELL=1: advance every edge after the switch edge.
    modec = 1'b1;
    push(2, 8'h11, 8'd0, 1'b0); tick();
    for (int i = 1; i <= 5; i++) begin
      push(2, cval[i % 4], 8'(i % 4), 1'b1);
      tick();
    end

    // Hold mid-dwell on DWELL=4.
    modea = 1'b1;
    push(0, 8'h33, 8'd2, 1'b0); tick();
    push(0, 8'h33, 8'd2, 1'b0); tick();
    push(0, 8'h33, 8'd2, 1'b0); tick();
    holda = 1'b1;
    xa    = 32'h44992211;
    for (int i = 0; i < 5; i++) begin
      push(0, 8'h33, 8'd2, 1'b0);
      tick();
    end
    holda = 1'b0;
    push(0, 8'h99, 8'd2, 1'b0); tick();
    push(0, 8'h44, 8'd3, 1'b1); tick();

    // Keep scanning through wrap to channel 1.
    for (int k = 0; k < 8; k++) begin
      if (k == 3)      push(0, 8'h11, 8'd0, 1'b1);
      else if (k == 7) push(0, 8'h99 & 8'h00 | 8'h22, 8'd1, 1'b1);
      else if (k < 3)  push(0, 8'h44, 8'd3, 1'b0);
      else             push(0, 8'h11, 8'd0, 1'b0);
      tick();
    end

    // sel ignored while scanning, then SCAN->MANUAL takes sel on the same edge.
    sela = 2'd3;
    push(0, 8'h22, 8'd1, 1'b0); tick();
    modea = 1'b0;
    push(0, 8'h44, 8'd3, 1'b1); tick();

    // Back to SCAN: first advance DWELL edges after the switch edge.
    modea = 1'b1;
    push(0, 8'h44, 8'd3, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      push(0, 8'h44, 8'd3, 1'b0);
      tick();
    end
    push(0, 8'h11, 8'd0, 1'b1); tick();

    // Reset mid-scan: scan re-arms only after release.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset(2, "midscan_rst");
    @(negedge clk);
    rst_n = 1'b1;
    push(2, 8'h11, 8'd0, 1'b0); tick();
    push(2, 8'h22, 8'd1, 1'b1); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
